axi_lite_mem_arbiter: RTL

//  Shares the single AXI4-lite memory slave port between NM masters: M0 = instruction fetch, M1 = execute load/store.
//  One transaction (read or write) is outstanding at a time. Channels of the granted master are muxed to the slave.

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/arb_grant.sv | 41 ++++
 rtl/axi_lite_mem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-lite memory arbiter.
// Optional round-robin arbitration is selected with ARB_ROUND_ROBIN_EN.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } arb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Index width for n masters; never zero so a single master still gets a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection over the master request vector.
// ARB_ROUND_ROBIN_EN: rotate priority after last_grant; otherwise highest index wins.
module arb_grant
    import axi_arb_pkg::*;
#(
    parameter  int unsigned NM = 2,
    localparam int unsigned GW = idx_w(NM)
) (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [GW-1:0] last_grant,
`endif
    input  logic [NM-1:0] req,
    output logic [GW-1:0] grant,
    output logic          valid
);

    logic [GW-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = |req;
`ifdef ARB_ROUND_ROBIN_EN
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = NM - 1; k >= 0; k--) begin
            idx = GW'((int'(last_grant) + 1 + k) % NM);
            if (req[idx]) begin
                grant = idx;
            end
        end
`else
        for (int i = 0; i < NM; i++) begin
            idx = GW'(i);
            if (req[idx]) begin
                grant = idx;
            end
        end
`endif
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI4-lite slave port between NM masters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module axi_lite_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int unsigned NM = 2,
    parameter  int unsigned AW = 32,
    parameter  int unsigned DW = 32,
    localparam int unsigned SW = DW / 8,
    localparam int unsigned GW = idx_w(NM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NM-1:0]    m_awvalid,
    output logic [NM-1:0]    m_awready,
    input  logic [NM*AW-1:0] m_awaddr,
    input  logic [NM*3-1:0]  m_awprot,
    input  logic [NM-1:0]    m_wvalid,
    output logic [NM-1:0]    m_wready,
    input  logic [NM*DW-1:0] m_wdata,
    input  logic [NM*SW-1:0] m_wstrb,
    output logic [NM-1:0]    m_bvalid,
    input  logic [NM-1:0]    m_bready,
    output logic [NM*2-1:0]  m_bresp,
    input  logic [NM-1:0]    m_arvalid,
    output logic [NM-1:0]    m_arready,
    input  logic [NM*AW-1:0] m_araddr,
    input  logic [NM*3-1:0]  m_arprot,
    output logic [NM-1:0]    m_rvalid,
    input  logic [NM-1:0]    m_rready,
    output logic [NM*DW-1:0] m_rdata,
    output logic [NM*2-1:0]  m_rresp,
    output logic             s_awvalid,
    input  logic             s_awready,
    output logic [AW-1:0]    s_awaddr,
    output logic [2:0]       s_awprot,
    output logic             s_wvalid,
    input  logic             s_wready,
    output logic [DW-1:0]    s_wdata,
    output logic [SW-1:0]    s_wstrb,
    input  logic             s_bvalid,
    output logic             s_bready,
    input  logic [1:0]       s_bresp,
    output logic             s_arvalid,
    input  logic             s_arready,
    output logic [AW-1:0]    s_araddr,
    output logic [2:0]       s_arprot,
    input  logic             s_rvalid,
    output logic             s_rready,
    input  logic [DW-1:0]    s_rdata,
    input  logic [1:0]       s_rresp,
    output logic [GW-1:0]    grant,
    output logic             busy
);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] sel;
    logic          sel_valid;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [NM-1:0] req;

    logic [AW-1:0] awaddr_a [NM];
    logic [AW-1:0] araddr_a [NM];
    logic [2:0]    awprot_a [NM];
    logic [2:0]    arprot_a [NM];
    logic [DW-1:0] wdata_a  [NM];
    logic [SW-1:0] wstrb_a  [NM];

    // Unpack the flat master buses so the grant index selects a whole field.
    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign awaddr_a[i] = m_awaddr[i*AW +: AW];
        assign araddr_a[i] = m_araddr[i*AW +: AW];
        assign awprot_a[i] = m_awprot[i*3 +: 3];
        assign arprot_a[i] = m_arprot[i*3 +: 3];
        assign wdata_a[i]  = m_wdata[i*DW +: DW];
        assign wstrb_a[i]  = m_wstrb[i*SW +: SW];
    end

    assign req     = m_arvalid | m_awvalid;
    assign grant   = grant_q;
    assign busy    = (state_q != IDLE);
    assign m_rdata = {NM{s_rdata}};
    assign m_rresp = {NM{s_rresp}};
    assign m_bresp = {NM{s_bresp}};

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0] last_grant_q, last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    arb_grant #(.NM(NM)) u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_q),
`endif
        .req        (req),
        .grant      (sel),
        .valid      (sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rvalid  = '0;
        s_awaddr  = awaddr_a[grant_q];
        s_awprot  = awprot_a[grant_q];
        s_wdata   = wdata_a[grant_q];
        s_wstrb   = wstrb_a[grant_q];
        s_araddr  = araddr_a[grant_q];
        s_arprot  = arprot_a[grant_q];

        case (state_q)
            IDLE: begin
                // A master with both requests pending does its write first.
                if (sel_valid) begin
                    grant_d = sel;
                    state_d = m_awvalid[sel] ? WR : RD_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = sel;
`endif
                end
            end
            RD_ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (s_arvalid && s_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
                if (s_rvalid && s_rready) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                // AW and W complete independently; each is masked once accepted.
                s_awvalid          = m_awvalid[grant_q] & ~aw_done_q;
                m_awready[grant_q] = s_awready & ~aw_done_q;
                s_wvalid           = m_wvalid[grant_q] & ~w_done_q;
                m_wready[grant_q]  = s_wready & ~w_done_q;
                aw_done_d          = aw_done_q | (s_awvalid & s_awready);
                w_done_d           = w_done_q | (s_wvalid & s_wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                s_bready          = m_bready[grant_q];
                m_bvalid[grant_q] = s_bvalid;
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
